// File: rtl/dram_bank_model.sv
// dram_bank_model
//   Single-bank DRAM device model. Decodes CSn/RASn/CASn/WEn into
//   ACT / READ / WRITE / PRE. Holds the open row. Returns read data CAS_LAT
//   cycles after the CAS command. Latches protocol misuse on a sticky flag.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   DRAM_CSn    in   chip select, active-low (high = NOP)
//   DRAM_RASn   in   row strobe, active-low
//   DRAM_CASn   in   column strobe, active-low
//   DRAM_WEn    in   [3:0] per-byte write enable, active-low (4'h0 with RAS = PRE)
//   DRAM_A      in   [10:0] row / column address
//   DRAM_D      in   [31:0] write data
//   DRAM_valid  out  one-cycle read data valid pulse
//   DRAM_Q      out  [31:0] read data, held until the next pulse
//   row_open    out  a row is activated
//   proto_err   out  sticky protocol error, cleared only by reset
//
// Optional feature
//   DRAM_TIMING_CHECK_EN: when defined, tRCD (ACT->CAS) and tRP (PRE->ACT)
//   violations also set proto_err. The offending command still executes.
//   When undefined, T_RCD and T_RP are unused.

module dram_bank_model #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int CAS_LAT  = 5,
  parameter int T_RCD    = 4,
  parameter int T_RP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic        DRAM_valid,
  output logic [31:0] DRAM_Q,
  output logic        row_open,
  output logic        proto_err
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef struct packed {
    logic ill;
    logic pre;
    logic act;
    logic rd;
    logic wr;
  } cmd_t;

  cmd_t                    w_cmd;
  logic                    w_rd_ok;
  logic                    w_wr_ok;
  logic                    w_act_ok;
  logic                    w_dec_err;
  logic                    w_tim_err;
  logic [ADDR_BITS-1:0]    w_addr;

  logic [ROW_BITS-1:0]     r_row;
  logic                    r_row_open;
  logic                    r_err;
  logic [CAS_LAT:1]        r_vld_pipe;
  logic [CAS_LAT:1][31:0]  r_dpipe;
  logic [3:0][7:0]         r_mem [DEPTH];

  // Command decode in priority order; RAS+CAS together wins over everything.
  always_comb begin
    w_cmd = '0;
    if (!DRAM_CSn) begin
      if (!DRAM_RASn && !DRAM_CASn) begin
        w_cmd.ill = 1'b1;
      end else if (!DRAM_RASn) begin
        if (DRAM_WEn == 4'h0) w_cmd.pre = 1'b1;
        else                  w_cmd.act = 1'b1;
      end else if (!DRAM_CASn) begin
        if (DRAM_WEn == 4'hF) w_cmd.rd = 1'b1;
        else                  w_cmd.wr = 1'b1;
      end
    end
  end

  assign w_rd_ok   = w_cmd.rd  &&  r_row_open;
  assign w_wr_ok   = w_cmd.wr  &&  r_row_open;
  assign w_act_ok  = w_cmd.act && !r_row_open;
  assign w_dec_err = w_cmd.ill
                   | (w_cmd.act && r_row_open)
                   | ((w_cmd.rd || w_cmd.wr) && !r_row_open);
  assign w_addr    = {r_row, DRAM_A[COL_BITS-1:0]};

`ifdef DRAM_TIMING_CHECK_EN
  localparam logic [3:0] LP_RCD = 4'(T_RCD);
  localparam logic [3:0] LP_RP  = 4'(T_RP);

  // Edges elapsed since the last accepted ACT / last PRE, saturating at 15.
  // Reset to 15 so the first commands after reset never look early.
  logic [3:0] r_act_cnt;
  logic [3:0] r_pre_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_cnt <= 4'hF;
      r_pre_cnt <= 4'hF;
    end else begin
      if (w_act_ok)                r_act_cnt <= 4'd1;
      else if (r_act_cnt != 4'hF)  r_act_cnt <= r_act_cnt + 4'd1;
      if (w_cmd.pre)               r_pre_cnt <= 4'd1;
      else if (r_pre_cnt != 4'hF)  r_pre_cnt <= r_pre_cnt + 4'd1;
    end
  end

  assign w_tim_err = ((w_cmd.rd || w_cmd.wr) && (r_act_cnt < LP_RCD))
                   | (w_cmd.act && (r_pre_cnt < LP_RP));
`else
  assign w_tim_err = 1'b0;
`endif

  // Open-row state. PRE with no row open simply leaves it closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= '0;
      r_row_open <= 1'b0;
    end else if (w_cmd.pre) begin
      r_row_open <= 1'b0;
    end else if (w_act_ok) begin
      r_row      <= DRAM_A[ROW_BITS-1:0];
      r_row_open <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_err <= 1'b0;
    else if (w_dec_err || w_tim_err) r_err <= 1'b1;
  end

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (!DRAM_WEn[i]) r_mem[w_addr][i] <= DRAM_D[8*i +: 8];
      end
    end
  end

  // Read pipeline. Stage 1 captures the array at the CAS edge, so a later
  // write to the same word cannot disturb a read already in flight. Each
  // stage only loads when its predecessor is valid, which makes the final
  // stage hold DRAM_Q between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_dpipe    <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd_ok;
      if (w_rd_ok) r_dpipe[1] <= r_mem[w_addr];
      for (int k = 2; k <= CAS_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dpipe[k] <= r_dpipe[k-1];
      end
    end
  end

  assign DRAM_valid = r_vld_pipe[CAS_LAT];
  assign DRAM_Q     = r_dpipe[CAS_LAT];
  assign row_open   = r_row_open;
  assign proto_err  = r_err;

endmodule
